// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: Q8.8 format constants
// and the sequencer state encoding.
package mult_arb_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  // Largest positive Q8.8 value, used when saturating an overflowed product.
  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// after the priority pointer, wrapping around, and reports it both as a
// one-hot grant and as an index. Usable for any shared datapath unit.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [ID_W-1:0] idx;

  // Walk from the farthest candidate back toward ptr+1 so the closest
  // requester after the pointer is the last one written and therefore wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one multi-cycle Q8.8 multiplier between
// NUM_REQ requesters. An accepted operand pair is held on mul_a/mul_b for
// MUL_LAT cycles, the product is captured and returned with the requester
// ID on a valid/ready response port.
// Build option: define MULT_ARB_SAT_EN to clamp overflowed products to the
// Q8.8 maximum; otherwise the raw multiplier output is returned.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 17,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_ovf,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_result,
  input  logic                      mul_ovf,
  output logic                      busy
);

  import mult_arb_pkg::*;

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_any;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic [DATA_W-1:0]    capture_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Grants are only offered while idle and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset) begin
      req_ready = grant;
    end
  end

  // Pick the winning requester's operands out of the packed buses.
  always_comb begin
    sel_a = req_a[int'(grant_id)*DATA_W +: DATA_W];
    sel_b = req_b[int'(grant_id)*DATA_W +: DATA_W];
  end

  // Product as it will be returned, optionally clamped on overflow.
  always_comb begin
`ifdef MULT_ARB_SAT_EN
    capture_data = mul_ovf ? DATA_W'(SAT_MAX) : mul_result;
`else
    capture_data = mul_result;
`endif
  end

  // Sequencer: accept one request, hold operands through the multiplier
  // latency, then present the response until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ - 1);
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            rsp_id <= grant_id;
            ptr    <= grant_id;
            cnt    <= CNT_W'(MUL_LAT - 1);
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= capture_data;
            rsp_ovf   <= mul_ovf;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
